// File: rtl/io_scan_ctrl_if.sv
// io_scan_ctrl_if: CPU-side I/O bus between the MEM stage and io_scan_ctrl.
//   addr         CPU byte address, only addr[7:2] is decoded
//   io_rd        one-cycle read strobe; a status read clears the change flags
//   io_read_data combinational read data for the current addr
//   io_wr        write strobe        (only with IO_SCAN_IRQ_EN)
//   io_wdata     write data, bit 0   (only with IO_SCAN_IRQ_EN)
// Macro: IO_SCAN_IRQ_EN adds the write path used by the irq_en register.
interface io_scan_ctrl_if;
  logic [31:0] addr;
  logic        io_rd;
  logic [31:0] io_read_data;
`ifdef IO_SCAN_IRQ_EN
  logic        io_wr;
  logic [31:0] io_wdata;

  modport master (output addr, io_rd, io_wr, io_wdata, input io_read_data);
  modport slave  (input addr, io_rd, io_wr, io_wdata, output io_read_data);
`else
  modport master (output addr, io_rd, input io_read_data);
  modport slave  (input addr, io_rd, output io_read_data);
`endif
endinterface

// File: rtl/io_scan_ctrl.sv
// io_scan_ctrl: paced, debounced sampling of two external input ports for the
// CPU I/O space. Only debounced values are visible; changes are latched into
// sticky clear-on-read flags, optionally raising a level interrupt.
// Ports:
//   io_clk    I/O clock, rising edge
//   resetn    asynchronous active-low reset
//   bus       io_scan_ctrl_if slave (addr, io_rd, io_read_data[, io_wr, io_wdata])
//   in_port0  raw asynchronous input port 0
//   in_port1  raw asynchronous input port 1
//   irq       registered level interrupt (tied 0 unless IO_SCAN_IRQ_EN)
// Register map (addr[7:2]): 0x20 stable0, 0x21 stable1,
//   0x22 status {30'b0, chg1, chg0} (clear-on-read), 0x23 irq_en (bit 0).
// Macro: IO_SCAN_IRQ_EN enables the irq_en register, the write path and irq.
module io_scan_ctrl #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned DEB_CNT  = 4
) (
  input  logic          io_clk,
  input  logic          resetn,
  io_scan_ctrl_if.slave bus,
  input  logic [31:0]   in_port0,
  input  logic [31:0]   in_port1,
  output logic          irq
);
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0] DEB_MAX = 4'(DEB_CNT);

  localparam logic [5:0] A_STABLE0 = 6'h20;
  localparam logic [5:0] A_STABLE1 = 6'h21;
  localparam logic [5:0] A_STATUS  = 6'h22;
  localparam logic [5:0] A_IRQEN   = 6'h23;

  logic [1:0][31:0] port_in;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [1:0][31:0] sync0_q, sync0_d, sync1_q, sync1_d;
  logic [1:0][31:0] cand_q, cand_d, stable_q, stable_d;
  logic [1:0][3:0]  cnt_q, cnt_d;
  logic [1:0]       chg_q, chg_d, chg_set;
  logic             tick, status_rd;
  logic             unused_addr;

  assign port_in[0]  = in_port0;
  assign port_in[1]  = in_port1;
  assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    sync0_d    = port_in;
    sync1_d    = sync0_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    chg_set    = '0;
    if (tick) begin
      for (int p = 0; p < 2; p++) begin
        if (sync1_q[p] != cand_q[p]) begin
          cand_d[p] = sync1_q[p];
          cnt_d[p]  = 4'd1;
        end else if (cnt_q[p] < DEB_MAX) begin
          cnt_d[p] = cnt_q[p] + 4'd1;
        end
        // Uses the post-update count so DEB_CNT=1 accepts on the loading tick.
        if (cnt_d[p] == DEB_MAX && cand_d[p] != stable_q[p]) begin
          stable_d[p] = cand_d[p];
          chg_set[p]  = 1'b1;
        end
      end
    end
    status_rd = bus.io_rd && (bus.addr[7:2] == A_STATUS);
    // A new change on the clearing edge survives the clear.
    chg_d     = (chg_q & ~{2{status_rd}}) | chg_set;
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_q <= '0;
      sync0_q    <= '0;
      sync1_q    <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      cnt_q      <= {2{DEB_MAX}};
      chg_q      <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync0_q    <= sync0_d;
      sync1_q    <= sync1_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      chg_q      <= chg_d;
    end
  end

`ifdef IO_SCAN_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  logic unused_wdata;

  assign unused_wdata = ^bus.io_wdata[31:1];

  always_comb begin
    irq_en_d = irq_en_q;
    if (bus.io_wr && bus.addr[7:2] == A_IRQEN) irq_en_d = bus.io_wdata[0];
    irq_d = (|chg_q) & irq_en_q;
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    bus.io_read_data = '0;
    case (bus.addr[7:2])
      A_STABLE0: bus.io_read_data = stable_q[0];
      A_STABLE1: bus.io_read_data = stable_q[1];
      A_STATUS:  bus.io_read_data = {30'b0, chg_q};
`ifdef IO_SCAN_IRQ_EN
      A_IRQEN:   bus.io_read_data = {31'b0, irq_en_q};
`endif
      default:   bus.io_read_data = '0;
    endcase
  end
endmodule

// File: tb/tb_io_scan_ctrl.sv
module tb_io_scan_ctrl;
  localparam int TICK_DIV = 4;
  localparam int DEB_CNT  = 3;

  logic        io_clk;
  logic        resetn;
  logic [31:0] in_port0, in_port1;
  logic        irq;

  io_scan_ctrl_if bus();

  io_scan_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CNT(DEB_CNT)) dut (
    .io_clk  (io_clk),
    .resetn  (resetn),
    .bus     (bus),
    .in_port0(in_port0),
    .in_port1(in_port1),
    .irq     (irq)
  );

  initial begin
    io_clk = 1'b0;
    forever #5 io_clk = ~io_clk;
  end

  // Reference model: a port value is accepted once the last DEB_CNT tick
  // samples of the 2-cycle-delayed input agree and differ from the current one.
  logic [31:0] m_s0 [2];
  logic [31:0] m_s1 [2];
  logic [31:0] m_stable [2];
  logic [31:0] m_win [2][DEB_CNT];
  logic [1:0]  m_chg;
  logic        m_en, m_irq;
  int          m_k;

  always @(posedge io_clk or negedge resetn) begin
    logic [1:0] set;
    logic       clr, same;
    if (!resetn) begin
      for (int p = 0; p < 2; p++) begin
        m_s0[p] = '0; m_s1[p] = '0; m_stable[p] = '0;
        for (int i = 0; i < DEB_CNT; i++) m_win[p][i] = '0;
      end
      m_chg = '0; m_en = 1'b0; m_irq = 1'b0; m_k = 0;
    end else begin
      clr = bus.io_rd && (bus.addr[7:2] == 6'h22);
`ifdef IO_SCAN_IRQ_EN
      m_irq = (|m_chg) && m_en;
      if (bus.io_wr && bus.addr[7:2] == 6'h23) m_en = bus.io_wdata[0];
`endif
      m_k++;
      set = '0;
      if (m_k % TICK_DIV == 0) begin
        for (int p = 0; p < 2; p++) begin
          for (int i = DEB_CNT - 1; i > 0; i--) m_win[p][i] = m_win[p][i-1];
          m_win[p][0] = m_s1[p];
          same = 1'b1;
          for (int i = 1; i < DEB_CNT; i++) if (m_win[p][i] != m_win[p][0]) same = 1'b0;
          if (same && m_win[p][0] != m_stable[p]) begin
            m_stable[p] = m_win[p][0];
            set[p] = 1'b1;
          end
        end
      end
      m_chg = (m_chg & ~{2{clr}}) | set;
      m_s1[0] = m_s0[0]; m_s1[1] = m_s0[1];
      m_s0[0] = in_port0; m_s0[1] = in_port1;
    end
  end

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    case (a[7:2])
      6'h20: return m_stable[0];
      6'h21: return m_stable[1];
      6'h22: return {30'b0, m_chg};
`ifdef IO_SCAN_IRQ_EN
      6'h23: return {31'b0, m_en};
`endif
      default: return 32'h0;
    endcase
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge io_clk);
    @(negedge io_clk);
    chk("rdata", bus.io_read_data, model_rd(bus.addr));
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  logic [31:0] saw1;
  logic [31:0] found;

  initial begin
    bus.addr = 32'd128; bus.io_rd = 1'b0;
`ifdef IO_SCAN_IRQ_EN
    bus.io_wr = 1'b0; bus.io_wdata = '0;
`endif
    in_port0 = 32'hFFFF; in_port1 = '0; resetn = 1'b0;
    repeat (3) cyc();
    for (int a = 0; a < 6; a++) begin
      bus.addr = 32'd128 + 32'(4 * a);
      #1 chk("rst_rd", bus.io_read_data, 32'h0);
    end
    bus.addr = 32'd0;
    #1 chk("rst_rd0", bus.io_read_data, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // Release with port0 high: accepted after the three-tick debounce.
    bus.addr = 32'd128;
    resetn = 1'b1;
    repeat (14) cyc();
    chk("rst_stable0", bus.io_read_data, 32'hFFFF);
    bus.addr = 32'd136; bus.io_rd = 1'b1;
    #1 chk("rst_chg0", bus.io_read_data, 32'h1);
    cyc(); bus.io_rd = 1'b0;

    // Clean change on port1.
    in_port1 = 32'h5A; bus.addr = 32'd132;
    repeat (20) cyc();
    chk("clean_p1", bus.io_read_data, 32'h5A);
    bus.addr = 32'd136; bus.io_rd = 1'b1;
    #1 chk("clean_status", bus.io_read_data, 32'h2);
    cyc(); bus.io_rd = 1'b0;

    // Short glitch on port0 must be rejected.
    bus.addr = 32'd128; in_port0 = 32'h1;
    repeat (5) cyc();
    in_port0 = 32'hFFFF;
    repeat (20) cyc();
    chk("glitch_p0", bus.io_read_data, 32'hFFFF);
    bus.addr = 32'd136;
    #1 chk("glitch_status", bus.io_read_data, 32'h0);

    // Clear-on-read returns the pre-clear value.
    in_port0 = 32'hF0; in_port1 = 32'h33;
    repeat (20) cyc();
    bus.io_rd = 1'b1;
    #1 chk("cor_first", bus.io_read_data, 32'h3);
    cyc(); bus.io_rd = 1'b0;
    #1 chk("cor_second", bus.io_read_data, 32'h0);

    // Continuous status reads while a port0 change lands: set must win.
    in_port0 = 32'h123; bus.io_rd = 1'b1; saw1 = '0;
    repeat (20) begin
      cyc();
      if (bus.io_read_data == 32'h1) saw1 = 32'h1;
    end
    bus.io_rd = 1'b0;
    chk("set_wins", saw1, 32'h1);

    // Reset in the middle of a debounce discards the partial count.
    bus.addr = 32'd128; in_port0 = 32'hABC;
    repeat (9) cyc();
    #2 resetn = 1'b0;
    #1 chk("mid_rst_stable0", bus.io_read_data, 32'h0);
    resetn = 1'b1;
    repeat (11) cyc();
    chk("redeb_wait", bus.io_read_data, 32'h0);
    cyc();
    chk("redeb_done", bus.io_read_data, 32'hABC);

`ifdef IO_SCAN_IRQ_EN
    bus.addr = 32'd136; bus.io_rd = 1'b1;
    cyc(); bus.io_rd = 1'b0;
    cyc();
    bus.addr = 32'd140; bus.io_wr = 1'b1; bus.io_wdata = 32'h1;
    cyc(); bus.io_wr = 1'b0;
    chk("irq_en_rd", bus.io_read_data, 32'h1);
    bus.addr = 32'd136; in_port0 = 32'h777; found = '0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (m_chg[0]) begin found = 32'h1; break; end
    end
    chk("irq_wait", found, 32'h1);
    chk("irq_pre", {31'b0, irq}, 32'h0);
    cyc();
    chk("irq_rise", {31'b0, irq}, 32'h1);
    bus.io_rd = 1'b1;
    cyc(); bus.io_rd = 1'b0;
    chk("irq_hold", {31'b0, irq}, 32'h1);
    cyc();
    chk("irq_fall", {31'b0, irq}, 32'h0);
`else
    bus.addr = 32'd140; in_port0 = 32'h777;
    repeat (20) cyc();
    #1 chk("irq_off_rd140", bus.io_read_data, 32'h0);
    chk("irq_off", {31'b0, irq}, 32'h0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0)
        case ($urandom_range(0, 3))
          0: in_port0 = 32'h0;
          1: in_port0 = 32'hFFFF;
          2: in_port0 = 32'h5A;
          default: in_port0 = $urandom;
        endcase
      if ($urandom_range(0, 15) == 0) in_port1 = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 9) == 0) bus.addr = $urandom;
      else bus.addr = 32'd128 + 32'(4 * $urandom_range(0, 4));
      bus.io_rd = ($urandom_range(0, 7) == 0);
`ifdef IO_SCAN_IRQ_EN
      bus.io_wr = ($urandom_range(0, 15) == 0);
      bus.io_wdata = $urandom;
`endif
      if ($urandom_range(0, 499) == 0) begin
        #1 resetn = 1'b0;
        #1 resetn = 1'b1;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
